// File: rtl/freq_meter_7seg.sv
// Counts sig_i rising edges per GATE_CYCLES window; result appears 1 cycle after gate end.
// Latched count is shown as 4 hex digits on a scanned common-anode display; no backpressure.
module freq_meter_7seg #(
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_WIDTH = 16,
  parameter int SCAN_DIV    = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sig_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   valid_o,
  output logic                   overflow_o,
  output logic [6:0]             seg_o,
  output logic [3:0]             an_o
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [GW-1:0]          GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]          SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

  logic                   sig_d_q;
  logic [GW-1:0]          gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] edge_q, edge_d;
  logic                   sat_q, sat_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [1:0]             idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;

  logic                   rise, gate_end, at_max, sat_now, scan_wrap;
  logic [COUNT_WIDTH-1:0] edge_final;
  logic [15:0]            disp;
  logic [3:0]             nib;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign rise     = sig_i & ~sig_d_q;
  assign gate_end = (gate_q == GATE_LAST);
  assign at_max   = (edge_q == CNT_MAX);
  assign sat_now  = rise & at_max;
  // A rise while already at full scale keeps the counter pinned and flags saturation.
  assign edge_final = (rise && !at_max) ? edge_q + 1'b1 : edge_q;

  assign scan_wrap = (scan_q == SCAN_LAST);
  assign disp      = 16'(count_q);

  always_comb begin
    gate_d  = gate_end ? '0 : gate_q + 1'b1;
    edge_d  = edge_final;
    sat_d   = sat_q | sat_now;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (gate_end) begin
      count_d = edge_final;
      ovf_d   = sat_q | sat_now;
      valid_d = 1'b1;
      edge_d  = '0;
      sat_d   = 1'b0;
    end

    scan_d = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d  = scan_wrap ? idx_q + 2'd1 : idx_q;
    // Glyph is fetched for the digit that becomes active on this edge.
    nib    = disp[{idx_d, 2'b00} +: 4];
    seg_d  = hex_glyph(nib);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_d_q <= 1'b1;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      seg_q   <= 7'b1000000;
    end else begin
      sig_d_q <= sig_i;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
    end
  end

  assign count_o    = count_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;
  assign seg_o      = seg_q;
  assign an_o       = ~(4'b0001 << idx_q);

endmodule
